// File: rtl/instruction_fetch_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int WORD_SIZE = 19,
    parameter int ADDR_SIZE = 12
);
    logic                 MEM_RD_REQ;
    logic [ADDR_SIZE-1:0] MEM_ADDR;
    logic                 MEM_RD_ACK;
    logic [WORD_SIZE-1:0] MEM_RD_DATA;

    modport master (output MEM_RD_REQ, MEM_ADDR, input MEM_RD_ACK, MEM_RD_DATA);
    modport slave  (input MEM_RD_REQ, MEM_ADDR, output MEM_RD_ACK, MEM_RD_DATA);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC, one-outstanding req/ack memory read, branch squash.
// Optional request timeout enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int                   WORD_SIZE      = 19,
    parameter int                   ADDR_SIZE      = 12,
    parameter logic [ADDR_SIZE-1:0] RESET_PC       = '0,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FETCH_REQ,
    input  logic                 HALT,
    input  logic                 BRANCH_LOAD,
    input  logic [ADDR_SIZE-1:0] BRANCH_TARGET,
    instruction_fetch_if.master  mem,
    output logic [WORD_SIZE-1:0] INSTR,
    output logic                 INSTR_VALID,
    output logic [ADDR_SIZE-1:0] PC,
    output logic                 FETCH_ERR
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t               state, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic                 req_q, req_d, vld_q, vld_d, sq_q, sq_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        sq_d    = sq_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (BRANCH_LOAD) pc_d = BRANCH_TARGET;
                if (FETCH_REQ && !HALT) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = BRANCH_LOAD ? BRANCH_TARGET : pc_q;
                    sq_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (BRANCH_LOAD) pc_d = BRANCH_TARGET;
                if (mem.MEM_RD_ACK) begin
                    // A redirect seen during the transfer turns the returning word into a bubble
                    if (!sq_q && !BRANCH_LOAD) begin
                        instr_d = mem.MEM_RD_DATA;
                        vld_d   = 1'b1;
                        pc_d    = addr_q + 1'b1;
                    end
                    req_d   = 1'b0;
                    sq_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (BRANCH_LOAD) sq_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        sq_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            sq_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            sq_q    <= sq_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem.MEM_RD_REQ = req_q;
    assign mem.MEM_ADDR   = addr_q;
    assign INSTR          = instr_q;
    assign INSTR_VALID    = vld_q;
    assign PC             = pc_q;
`ifdef FETCH_TIMEOUT_EN
    assign FETCH_ERR      = err_q;
`else
    assign FETCH_ERR      = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed test-plan cases then random traffic.
module tb_instruction_fetch;
    localparam int WS = 19, AS = 12, TMO = 4;

    logic          CLK = 1'b0, RST = 1'b1, FETCH_REQ = 1'b0, HALT = 1'b0, BRANCH_LOAD = 1'b0;
    logic [AS-1:0] BRANCH_TARGET = '0;
    logic [WS-1:0] INSTR;
    logic          INSTR_VALID, FETCH_ERR;
    logic [AS-1:0] PC;

    instruction_fetch_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) mem ();

    instruction_fetch #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .RESET_PC(12'h000), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .FETCH_REQ(FETCH_REQ), .HALT(HALT), .BRANCH_LOAD(BRANCH_LOAD),
        .BRANCH_TARGET(BRANCH_TARGET), .mem(mem), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .PC(PC), .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model state: what the fetch unit should look like after each edge
    logic          m_busy = 0, m_sq = 0, m_vld = 0, m_err = 0;
    logic [AS-1:0] m_addr = '0, m_pc = '0;
    logic [WS-1:0] m_instr = '0;
    int            m_wait = 0;
    logic [WS-1:0] exp_q[$];
    int            total = 0, bad = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic fr, input logic h, input logic bl,
                         input logic [AS-1:0] t, input logic a, input logic [WS-1:0] d);
        m_vld = 0;
        m_err = 0;
        if (r) begin
            m_busy = 0; m_sq = 0; m_addr = '0; m_pc = '0; m_instr = '0; m_wait = 0;
        end else if (!m_busy) begin
            if (fr && !h) begin
                m_busy = 1; m_sq = 0; m_wait = 0;
                m_addr = bl ? t : m_pc;
            end
            if (bl) m_pc = t;
        end else if (a) begin
            if (bl) m_pc = t;
            else if (!m_sq) begin
                m_instr = d;
                m_vld   = 1;
                exp_q.push_back(d);
                m_pc    = m_addr + 12'd1;
            end
            m_busy = 0; m_sq = 0;
        end else begin
            if (bl) begin m_pc = t; m_sq = 1; end
            m_wait++;
`ifdef FETCH_TIMEOUT_EN
            if (m_wait == TMO) begin m_busy = 0; m_sq = 0; m_err = 1; end
`endif
        end
    endtask

    task automatic cyc(input logic r, input logic fr, input logic h, input logic bl,
                       input logic [AS-1:0] t, input logic a, input logic [WS-1:0] d);
        @(negedge CLK);
        RST = r; FETCH_REQ = fr; HALT = h; BRANCH_LOAD = bl; BRANCH_TARGET = t;
        mem.MEM_RD_ACK = a; mem.MEM_RD_DATA = d;
        @(posedge CLK);
        model(r, fr, h, bl, t, a, d);
    endtask

    // Monitor: compares DUT outputs to the model half a cycle after each edge
    initial begin
        logic [WS-1:0] e;
        forever begin
            @(negedge CLK);
            chk("pc", 32'(PC), 32'(m_pc));
            chk("rd_req", 32'(mem.MEM_RD_REQ), 32'(m_busy));
            chk("mem_addr", 32'(mem.MEM_ADDR), 32'(m_addr));
            chk("instr_hold", 32'(INSTR), 32'(m_instr));
            chk("instr_valid", 32'(INSTR_VALID), 32'(m_vld));
            chk("fetch_err", 32'(FETCH_ERR), 32'(m_err));
            if (INSTR_VALID) begin
                if (exp_q.size() == 0) chk("sb_empty", 32'(INSTR), 32'hFFFFFFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", 32'(INSTR), 32'(e));
                end
            end else if (m_vld && exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end
        end
    end

    initial begin
        mem.MEM_RD_ACK = 0;
        mem.MEM_RD_DATA = '0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // First fetch, ack in the first REQ cycle
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 19'h5A3C1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Redirect to 0xFFF, fetch with 3 wait cycles, PC wraps to 0
        cyc(0, 1, 0, 1, 12'hFFF, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 19'h12345);
        // Branch and fetch together in IDLE
        cyc(0, 1, 0, 1, 12'h200, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 19'h7FFFF);
        // Branch during REQ squashes the returning word
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 12'h080, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 19'h0BEEF);
        // HALT blocks fetch, spurious ack in IDLE ignored
        repeat (3) cyc(0, 1, 1, 0, 0, 1, 19'h11111);
        // Reset mid-transfer, then a late ack
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 19'h22222);
        cyc(0, 0, 0, 0, 0, 1, 19'h33333);
        // Long wait without ack (times out when the timeout option is built in)
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 19'h44444);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [AS-1:0] t;
            t = ($urandom_range(0, 7) == 0) ? 12'hFFF : AS'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, t, $urandom_range(0, 4) < 2, WS'($urandom));
        end
        repeat (2) @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the 19-bit CPU that produces the instruction words the instruction register captures. Owns the program counter, performs one memory read per fetch request over a req/ack handshake, and delivers the fetched word with a single-cycle valid strobe that the control unit uses to load the instruction register. Branch redirects and halt also enter here.

## Interface
- WORD_SIZE, 19, instruction word width
- ADDR_SIZE, 12, program counter / memory address width
- RESET_PC, 0, PC value after reset
- TIMEOUT_CYCLES, 16, cycles MEM_RD_REQ may stay high without ACK before error (only with FETCH_TIMEOUT_EN)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset; synchronous and active-high
- FETCH_REQ  in  1  control unit requests the next instruction
- HALT  in  1  blocks new fetches while high
- BRANCH_LOAD  in  1  load PC from BRANCH_TARGET
- BRANCH_TARGET  in  ADDR_SIZE  redirect address
- MEM_RD_REQ  out  1  memory read request, held until ACK
- MEM_ADDR  out  ADDR_SIZE  read address, stable while MEM_RD_REQ high
- MEM_RD_ACK  in  1  memory returns data this cycle
- MEM_RD_DATA  in  WORD_SIZE  read data, sampled when MEM_RD_ACK high
- INSTR  out  WORD_SIZE  last delivered instruction word, held
- INSTR_VALID  out  1  one-cycle pulse: INSTR is new, load IR
- PC  out  ADDR_SIZE  address of the next instruction to fetch
- FETCH_ERR  out  1  one-cycle pulse on timeout (FETCH_TIMEOUT_EN only, else tied 0)

## Operation
- States: IDLE, REQ.
- Reset: state IDLE, PC=RESET_PC, MEM_ADDR=0, MEM_RD_REQ=0, INSTR=0, INSTR_VALID=0, FETCH_ERR=0, squash flag and timeout counter cleared. Reset in REQ abandons the transfer; a late ACK is ignored.
- IDLE: MEM_RD_REQ=0. MEM_RD_ACK ignored.
  - BRANCH_LOAD: PC<=BRANCH_TARGET.
  - FETCH_REQ && !HALT: go REQ, MEM_RD_REQ<=1, MEM_ADDR<=(BRANCH_LOAD ? BRANCH_TARGET : PC). Branch wins when simultaneous.
  - FETCH_REQ && HALT: no action.
- REQ: MEM_RD_REQ and MEM_ADDR held. FETCH_REQ and HALT ignored.
  - BRANCH_LOAD: PC<=BRANCH_TARGET, set squash flag; transfer still completes.
  - MEM_RD_ACK, no squash (and no BRANCH_LOAD this cycle): INSTR<=MEM_RD_DATA, INSTR_VALID<=1, PC<=MEM_ADDR+1 modulo 2^ADDR_SIZE, MEM_RD_REQ<=0, go IDLE.
  - MEM_RD_ACK with squash set or BRANCH_LOAD this cycle: data dropped, INSTR unchanged, no INSTR_VALID, PC=target, squash cleared, go IDLE.
- PC wraps from 2^ADDR_SIZE-1 to 0 with no flag.

## Timing
- FETCH_REQ sampled at edge n: MEM_RD_REQ=1, MEM_ADDR valid after edge n.
- MEM_RD_ACK sampled at edge m (m>n): after edge m INSTR valid, INSTR_VALID=1 for exactly one cycle, PC incremented, MEM_RD_REQ=0.
- Minimum FETCH_REQ-to-INSTR_VALID: 2 edges (ACK combinational in first REQ cycle).
- Next fetch issues at earliest on FETCH_REQ sampled during the INSTR_VALID cycle; at most one transfer outstanding.
- INSTR holds its value until the next non-squashed ACK.

## Configuration
- FETCH_TIMEOUT_EN defined: counter clears on entering REQ, increments each REQ cycle without ACK; when it reaches TIMEOUT_CYCLES, MEM_RD_REQ<=0, FETCH_ERR pulses one cycle, PC unchanged, squash cleared, go IDLE. ACK on the same cycle the limit is reached is honoured (ACK wins).
- Not defined: no counter, REQ waits indefinitely, FETCH_ERR constant 0.

## Test plan
- Reset, FETCH_REQ, ACK in first REQ cycle with data 19'h5A3C1 -> MEM_ADDR=0, INSTR=19'h5A3C1, INSTR_VALID one cycle 2 edges after request, PC=1.
- PC=12'hFFF, fetch with ACK after 3 wait cycles -> MEM_ADDR stable 12'hFFF throughout, PC wraps to 0.
- BRANCH_LOAD=1 target 12'h200 with FETCH_REQ in IDLE -> MEM_ADDR=12'h200; after ACK PC=12'h201.
- BRANCH_LOAD to 12'h080 during REQ, ACK two cycles later -> no INSTR_VALID, INSTR unchanged, PC=12'h080.
- HALT=1 with FETCH_REQ -> MEM_RD_REQ stays 0; RST asserted mid-REQ then ACK -> all outputs reset values, no INSTR_VALID.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ACK -> MEM_RD_REQ drops and FETCH_ERR pulses after 4 REQ cycles, PC unchanged.
